// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: source select, load funct3 codes and FSM states.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_IMM = 2'd2,
        WB_PC4 = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB instruction bus, data-memory response and register-file write port.
interface wb_stage_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int REGW = $clog2(NREG);

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_wbsel;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc4;
    logic [REGW-1:0] in_rd;
    logic            in_wreg;
    logic            dmem_rsp_valid;
    logic [XLEN-1:0] dmem_rsp_data;
    logic            wb_valid;
    logic            wb_we;
    logic [REGW-1:0] wb_rd;
    logic [XLEN-1:0] wb_wdata;

    modport master (
        output in_valid, in_wbsel, in_funct3, in_alu_result, in_imm, in_pc4,
               in_rd, in_wreg, dmem_rsp_valid, dmem_rsp_data,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_wdata
    );

    modport slave (
        input  in_valid, in_wbsel, in_funct3, in_alu_result, in_imm, in_pc4,
               in_rd, in_wreg, dmem_rsp_valid, dmem_rsp_data,
        output in_ready, wb_valid, wb_we, wb_rd, wb_wdata
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load alignment: byte-offset shift then sign/zero extension by funct3.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] data,
    input  logic [OFFW-1:0] offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] v, input logic sgn);
        logic signed [7:0] sv;
        sv = v;
        return sgn ? XLEN'(sv) : XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] v, input logic sgn);
        logic signed [15:0] sv;
        sv = v;
        return sgn ? XLEN'(sv) : XLEN'(v);
    endfunction

    // On a 32-bit datapath a signed word extension is the identity.
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
        logic signed [31:0] sv;
        sv = v;
        return sgn ? XLEN'(sv) : XLEN'(v);
    endfunction

    assign shifted = data >> {offset, 3'b000};

    always_comb begin
        result = ext32(shifted[31:0], 1'b0);
        case (funct3)
            F3_LB:   result = ext8(shifted[7:0], 1'b1);
            F3_LH:   result = ext16(shifted[15:0], 1'b1);
            F3_LW:   result = ext32(shifted[31:0], 1'b1);
            F3_LD:   result = shifted;
            F3_LBU:  result = ext8(shifted[7:0], 1'b0);
            F3_LHU:  result = ext16(shifted[15:0], 1'b0);
            F3_LWU:  result = ext32(shifted[31:0], 1'b0);
            default: result = ext32(shifted[31:0], 1'b0);
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle, stalls on loads until the
// data-memory response arrives, supports flush and counts retired instructions.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int CNTW = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    wb_stage_if.slave       bus,
    output logic [CNTW-1:0] instret
);

    localparam int REGW = $clog2(NREG);
    localparam int OFFW = $clog2(XLEN / 8);

    wb_state_e state, state_nxt;
    logic            accept;
    logic            is_load;
    logic            retire;
    logic [XLEN-1:0] src_data;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] ret_data;
    logic [REGW-1:0] ret_rd;
    logic            ret_wreg;

    logic [2:0]      ld_funct3_p0;
    logic [OFFW-1:0] ld_off_p0;
    logic [REGW-1:0] ld_rd_p0;
    logic            ld_wreg_p0;

    assign is_load      = (wb_sel_e'(bus.in_wbsel) == WB_MEM);
    assign bus.in_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && !flush) begin
                    accept = 1'b1;
                    if (is_load) state_nxt = WAIT;
                    else         retire    = 1'b1;
                end
            end
            WAIT: begin
                // A response landing together with a flush is dropped, not drained later.
                if (flush) begin
                    state_nxt = bus.dmem_rsp_valid ? IDLE : DRAIN;
                end else if (bus.dmem_rsp_valid) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (bus.dmem_rsp_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_data = bus.in_alu_result;
        case (wb_sel_e'(bus.in_wbsel))
            WB_PC4:  src_data = bus.in_pc4;
            WB_IMM:  src_data = bus.in_imm;
            default: src_data = bus.in_alu_result;
        endcase
    end

    load_align #(
        .XLEN (XLEN),
        .OFFW (OFFW)
    ) u_load_align (
        .data   (bus.dmem_rsp_data),
        .offset (ld_off_p0),
        .funct3 (ld_funct3_p0),
        .result (ld_data)
    );

    always_comb begin
        ret_data = src_data;
        ret_rd   = bus.in_rd;
        ret_wreg = bus.in_wreg;
        if (state == WAIT) begin
            ret_data = ld_data;
            ret_rd   = ld_rd_p0;
            ret_wreg = ld_wreg_p0;
        end
    end

    // Stage p0: fields of a load held while it waits for memory.
    always_ff @(posedge clk) begin
        if (accept && is_load) begin
            ld_funct3_p0 <= bus.in_funct3;
            ld_off_p0    <= bus.in_alu_result[OFFW-1:0];
            ld_rd_p0     <= bus.in_rd;
            ld_wreg_p0   <= bus.in_wreg;
        end
    end

    // Register-file write port and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus.wb_valid <= 1'b0;
            bus.wb_we    <= 1'b0;
            bus.wb_rd    <= '0;
            bus.wb_wdata <= '0;
            instret      <= '0;
        end else begin
            state        <= state_nxt;
            bus.wb_valid <= retire;
            bus.wb_we    <= retire && ret_wreg && (ret_rd != '0);
            if (retire) begin
                bus.wb_rd    <= ret_rd;
                bus.wb_wdata <= ret_data;
                instret      <= instret + CNTW'(1);
            end
        end
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised write-back stage for the pipelined RISC-V core, sitting between the MEM stage and the register file. It accepts one instruction per cycle from MEM, waits for the data-memory response on loads, then aligns and sign/zero-extends the loaded bytes. It selects the write-back source and drives a single-cycle register-file write. It also keeps a retired-instruction counter and supports pipeline flush, including the case of a load still waiting on memory.

## Interface
Parameters:
- `XLEN`, 32: datapath width; 32 or 64.
- `NREG`, 32: architectural register count; `REGW = $clog2(NREG)`.
- `CNTW`, 64: width of the retire counter.

Ports:
- `clk` in 1: the single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: MEM stage presents an instruction.
- `in_ready` out 1: stage can accept; equals `state==IDLE`.
- `in_wbsel` in 2: write-back source (`WB_ALU`/`WB_MEM`/`WB_IMM`/`WB_PC4`).
- `in_funct3` in 3: load size/sign.
- `in_alu_result` in XLEN: ALU result; low `$clog2(XLEN/8)` bits give the load byte offset.
- `in_imm` in XLEN: immediate value.
- `in_pc4` in XLEN: PC+4.
- `in_rd` in REGW: destination register.
- `in_wreg` in 1: instruction writes rd.
- `flush` in 1: kill the in-flight or presented instruction.
- `dmem_rsp_valid` in 1: data-memory response strobe.
- `dmem_rsp_data` in XLEN: aligned memory word.
- `wb_valid` out 1: one-cycle retire pulse.
- `wb_we` out 1: register-file write enable.
- `wb_rd` out REGW: register-file write address.
- `wb_wdata` out XLEN: register-file write data.
- `instret` out CNTW: count of retired instructions.

## Operation
- Load means `in_wbsel==WB_MEM`.
- FSM states:
  - `IDLE`: accept on `in_valid && !flush`. A non-load stays in `IDLE` and registers its output. A load captures its fields and goes to `WAIT`.
  - `WAIT`: on `dmem_rsp_valid && !flush`, retire the load and go to `IDLE`. On `flush` with no response this cycle, go to `DRAIN`. On `flush` with a response this cycle, discard the response and go to `IDLE`.
  - `DRAIN`: discard the next `dmem_rsp_valid`, then go to `IDLE`. `flush` has no effect in this state.
- `dmem_rsp_valid` is ignored in `IDLE`.
- Source mux:
  - `WB_PC4` → `in_pc4`
  - `WB_IMM` → `in_imm`
  - `WB_ALU` → `in_alu_result`
  - `WB_MEM` → extended load data
- Load extension: shift `dmem_rsp_data` right by offset×8 with zero fill, then extend:
  - LB 000 and LH 001: sign-extend from bit 7 / bit 15.
  - LW 010: sign-extend when XLEN=64, pass-through when XLEN=32.
  - LBU 100, LHU 101, LWU 110: zero-extend.
  - LD 011: pass-through.
  - Any other `in_funct3` code: zero-extended word.
- `wb_we = in_wreg && (rd != 0)`. Retiring to x0 still pulses `wb_valid` and increments `instret`.
- `instret` increments by 1 per `wb_valid` and wraps modulo 2^CNTW.

## Timing
- Reset values: state `IDLE`; `wb_valid`, `wb_we`, `wb_rd`, `wb_wdata` and `instret` all 0; `in_ready` 1 while `rst_n` is low.
- Non-load accepted at edge k: `wb_*` valid in the cycle after edge k for exactly one cycle. Back-to-back throughput is 1 per cycle.
- Load accepted at edge k: the response is sampled at edge m ≥ k+1, and `wb_*` is valid in the cycle after edge m. `in_ready` is low from edge k until edge m.
- `wb_valid` and `wb_we` are 0 in every cycle without a retire. `wb_rd` and `wb_wdata` hold their last values.
- `flush` and `in_valid` in the same cycle: nothing is accepted and nothing is retired.
- A flush never suppresses a retire already registered on the outputs.
- `rst_n` asserted mid-`WAIT`: everything clears immediately. Any later stale response is ignored because the state is `IDLE`.

## Structure
- `wb_pkg` holds:
  - the `wb_sel_e` enum (`WB_ALU`=0, `WB_MEM`=1, `WB_IMM`=2, `WB_PC4`=3);
  - the load `funct3` localparams;
  - the FSM `wb_state_e` enum.
- One sub-module, `load_align` (combinational): byte shift plus sign/zero extension, parametrised by XLEN.

## Test plan
- ALU, IMM and PC4 instructions on 3 consecutive cycles (rd=5,6,7) → three back-to-back `wb_valid` pulses with the correct data; `instret` reaches 3.
- LB with offset 3, response 0x80FF_FFFF, rsp 2 cycles after accept → `wb_wdata`=0xFFFF_FF80 one cycle after rsp; `in_ready` low for 2 cycles.
- LHU with offset 2 on response 0xBEEF_0000 → 0x0000_BEEF. XLEN=64 LW of 0x8000_0000 → 0xFFFF_FFFF_8000_0000.
- Load accepted, `flush` 1 cycle later, response 3 cycles later → FSM passes through `DRAIN`, no `wb_valid`, `instret` unchanged, next instruction accepted after the response.
- Write to rd=0 with `in_wreg`=1 → `wb_valid`=1, `wb_we`=0, `instret`+1. Preload `instret` to 2^CNTW−1 (force), retire once → 0.
- `rst_n` low during `WAIT`, response arrives after release → no retire, all outputs 0.
